// File: rtl/iguana_uart_rx_monitor.sv
// Deframes 8N1 serial from the DUT uart_tx pad into a byte FIFO with valid/ready drain.
// Latency: byte visible on data_o one cycle after the stop-bit sample; pulses are registered.
// Backpressure: ready_i low lets the FIFO fill; a byte arriving to a full FIFO is dropped and overflow_o latches.
module iguana_uart_rx_monitor #(
    parameter int ClkFreqHz = 50_000_000,
    parameter int BaudRate  = 115_200,
    parameter int FifoDepth = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           rx_i,
    output logic [7:0]                     data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           frame_err_o,
    output logic                           newline_o,
    output logic                           overflow_o,
    output logic [$clog2(FifoDepth+1)-1:0] fill_o,
    output logic                           busy_o
);
    localparam int BitCycles = ClkFreqHz / BaudRate;
    localparam int CntW      = $clog2(BitCycles);
    localparam int PtrW      = $clog2(FifoDepth);
    localparam int FillW     = $clog2(FifoDepth + 1);

    if (BitCycles < 4) begin : g_bad_baud
        $error("iguana_uart_rx_monitor: ClkFreqHz/BaudRate must be >= 4");
    end
    if (FifoDepth < 2) begin : g_bad_depth
        $error("iguana_uart_rx_monitor: FifoDepth must be >= 2");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic            r_sync1, r_sync2, r_rxq;
    state_t          r_state, w_state_nxt;
    logic [CntW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]      r_idx, w_idx_nxt;
    logic [7:0]      r_shreg, w_shreg_nxt;
    logic            w_rx_s, w_sample, w_push, w_ferr;
    logic            r_frame_err, r_newline, r_overflow;

    logic [7:0]      r_mem [FifoDepth];
    logic [PtrW-1:0] r_wptr, r_rptr;
    logic [FillW-1:0] r_fill;
    logic            w_valid, w_full, w_pop, w_wr, w_drop;

    assign w_rx_s   = r_sync2;
    assign w_sample = (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shreg_nxt = r_shreg;
        w_push      = 1'b0;
        w_ferr      = 1'b0;
        if (r_state != S_IDLE && !w_sample) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
        case (r_state)
            S_IDLE: begin
                if (r_rxq && !w_rx_s) begin
                    w_cnt_nxt   = CntW'(BitCycles / 2 - 1);
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_sample) begin
                    if (!w_rx_s) begin
                        w_cnt_nxt   = CntW'(BitCycles - 1);
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_sample) begin
                    w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
                    w_cnt_nxt   = CntW'(BitCycles - 1);
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (w_sample) begin
                    w_push      = w_rx_s;
                    w_ferr      = !w_rx_s;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_rxq       <= 1'b1;
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx_i;
            r_sync2     <= r_sync1;
            r_rxq       <= r_sync2;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shreg     <= w_shreg_nxt;
            r_frame_err <= w_ferr;
        end
    end

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign w_valid = (r_fill != '0);
    assign w_full  = (r_fill == FillW'(FifoDepth));
    assign w_pop   = w_valid && ready_i;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FifoDepth; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_fill     <= '0;
            r_newline  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= r_shreg;
                r_wptr <= (r_wptr == PtrW'(FifoDepth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PtrW'(FifoDepth - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_fill <= r_fill + 1'b1;
            end else if (w_pop && !w_wr) begin
                r_fill <= r_fill - 1'b1;
            end
            r_newline <= w_wr && (r_shreg == 8'h0A);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign data_o      = r_mem[r_rptr];
    assign valid_o     = w_valid;
    assign fill_o      = r_fill;
    assign frame_err_o = r_frame_err;
    assign newline_o   = r_newline;
    assign overflow_o  = r_overflow;
    assign busy_o      = (r_state != S_IDLE);

endmodule
